// File: rtl/dac_wave_buffer.sv
// AXI-style byte write port into a sample RAM plus a looping DAC playback engine.
// Optional DAC_WAVE_SAMPLE_STROBE_EN adds dac_sample_stb, pulsed on each dac_data update.
module dac_wave_buffer #(
    parameter int ADDR_W = 10
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic [15:0]       dac_axi_awaddr,
    input  logic              dac_axi_awvalid,
    output logic              dac_axi_awready,
    input  logic [7:0]        dac_axi_wdata,
    input  logic              dac_axi_wvalid,
    output logic              dac_axi_wready,
    input  logic              dac_axi_wlast,
    output logic [1:0]        dac_axi_bresp,
    output logic              dac_axi_bvalid,
    input  logic              dac_axi_bready,
    input  logic              cfg_play_en,
    input  logic [15:0]       cfg_div,
    input  logic [ADDR_W:0]   cfg_len,
`ifdef DAC_WAVE_SAMPLE_STROBE_EN
    output logic              dac_sample_stb,
`endif
    output logic [7:0]        dac_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [16:0]     DEPTH17 = 17'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    wr_state_t         state_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [15:0]       wr_ptr_q;
    logic              err_q;

    logic [7:0]        mem [DEPTH];
    logic              in_range;
    logic              mem_we;

    logic [15:0]       div_cnt_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [7:0]        dac_data_q;
    logic [ADDR_W:0]   rd_last;
    logic              tick;

    assign in_range = ({1'b0, wr_ptr_q} < DEPTH17);
    // A beat coinciding with reset belongs to an abandoned burst and is not stored.
    assign mem_we   = !axi_areset && (state_q == W_DATA) && dac_axi_wvalid && in_range;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (dac_axi_awvalid && awready_q) begin
                        wr_ptr_q  <= dac_axi_awaddr;
                        err_q     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (dac_axi_wvalid) begin
                        wr_ptr_q <= wr_ptr_q + 16'd1;
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end
                        if (dac_axi_wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q || !in_range) ? 2'b10 : 2'b00;
                            state_q  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (dac_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        awready_q <= 1'b1;
                        state_q   <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (mem_we) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= dac_axi_wdata;
        end
    end

    // Last playable index: length 0 plays one sample, oversize lengths play the whole RAM.
    always_comb begin
        rd_last = '0;
        if (cfg_len == '0) begin
            rd_last = '0;
        end else if (cfg_len > DEPTH_L) begin
            rd_last = DEPTH_L - (ADDR_W + 1)'(1);
        end else begin
            rd_last = cfg_len - (ADDR_W + 1)'(1);
        end
    end

    assign tick = (div_cnt_q == cfg_div);

    always_ff @(posedge axi_aclk) begin
        if (axi_areset || !cfg_play_en) begin
            div_cnt_q  <= '0;
            rd_ptr_q   <= '0;
            dac_data_q <= 8'h80;
        end else if (tick) begin
            div_cnt_q  <= '0;
            dac_data_q <= mem[rd_ptr_q];
            rd_ptr_q   <= ({1'b0, rd_ptr_q} == rd_last) ? '0 : rd_ptr_q + ADDR_W'(1);
        end else begin
            div_cnt_q  <= div_cnt_q + 16'd1;
        end
    end

`ifdef DAC_WAVE_SAMPLE_STROBE_EN
    logic stb_q;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset || !cfg_play_en) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= tick;
        end
    end

    assign dac_sample_stb = stb_q;
`endif

    assign dac_axi_awready = awready_q;
    assign dac_axi_wready  = wready_q;
    assign dac_axi_bvalid  = bvalid_q;
    assign dac_axi_bresp   = bresp_q;
    assign dac_data        = dac_data_q;

endmodule

// File: tb/tb_dac_wave_buffer.sv
// Scoreboard bench for dac_wave_buffer: write responses and per-cycle DAC samples
// are predicted from a byte-array model of the RAM and checked by negedge monitors.
module tb_dac_wave_buffer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              axi_areset;
    logic [15:0]       awaddr;
    logic              awvalid;
    logic              awready;
    logic [7:0]        wdata;
    logic              wvalid;
    logic              wready;
    logic              wlast;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic              play_en;
    logic [15:0]       cfg_div;
    logic [ADDR_W:0]   cfg_len;
    logic [7:0]        dac_data;

    always #5 clk = ~clk;

    dac_wave_buffer #(.ADDR_W(ADDR_W)) dut (
        .axi_aclk        (clk),
        .axi_areset      (axi_areset),
        .dac_axi_awaddr  (awaddr),
        .dac_axi_awvalid (awvalid),
        .dac_axi_awready (awready),
        .dac_axi_wdata   (wdata),
        .dac_axi_wvalid  (wvalid),
        .dac_axi_wready  (wready),
        .dac_axi_wlast   (wlast),
        .dac_axi_bresp   (bresp),
        .dac_axi_bvalid  (bvalid),
        .dac_axi_bready  (bready),
        .cfg_play_en     (play_en),
        .cfg_div         (cfg_div),
        .cfg_len         (cfg_len),
        .dac_data        (dac_data)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [DEPTH];
    logic [7:0] bd    [DEPTH];
    logic [1:0] b_q   [$];
    int         dac_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Sample seen after m enabled edges: one new sample every div+1 edges, looping over le bytes.
    function automatic int exp_sample(input int m, input int div, input int le);
        int ticks;
        ticks = m / (div + 1);
        if (ticks == 0) return 128;
        return int'(mem_m[(ticks - 1) % le]);
    endfunction

    always @(negedge clk) begin
        if (!axi_areset && bvalid) begin
            if (b_q.size() == 0) begin
                check("unexpected_bvalid", 32'(bvalid), 32'd0);
            end else begin
                check("bresp", 32'(bresp), 32'(b_q[0]));
                check("awready_during_resp", 32'(awready), 32'd0);
                if (bready) void'(b_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (dac_q.size() > 0) begin
            int e;
            e = dac_q.pop_front();
            check("dac_data", 32'(dac_data), 32'(e));
        end
    end

    task automatic burst(input logic [15:0] addr, input int n, input int hold, input int abort_at);
        logic [15:0] ptr;
        logic        err;
        int          t;
        int          cnt;
        @(posedge clk); #1;
        awaddr  = addr;
        awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("aw_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        ptr = addr;
        err = 1'b0;
        for (int b = 0; b < n; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wdata  = bd[b];
            wvalid = 1'b1;
            wlast  = (b == n - 1);
            if (b == abort_at) begin
                axi_areset = 1'b1;
                @(posedge clk); #1;
                axi_areset = 1'b0;
                wvalid = 1'b0;
                wlast  = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    check("no_bvalid_after_abort", 32'(bvalid), 32'd0);
                end
                $display("burst addr=%04h beats=%0d aborted at beat %0d", addr, n, b);
                return;
            end
            @(negedge clk);
            check("wready_in_data", 32'(wready), 32'd1);
            @(posedge clk); #1;
            if (32'(ptr) < DEPTH) mem_m[ptr[ADDR_W-1:0]] = bd[b];
            else err = 1'b1;
            ptr = ptr + 16'd1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        b_q.push_back(err ? 2'b10 : 2'b00);
        bready = (hold == 0);
        t = 0;
        @(negedge clk);
        while (!bvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bvalid_seen", 32'(bvalid), 32'd1);
        if (bvalid) begin
            cnt = 0;
            while (bvalid && t < 60) begin
                cnt++;
                @(posedge clk); #1;
                if (cnt >= hold) bready = 1'b1;
                @(negedge clk);
                t++;
            end
            check("bvalid_hold_cycles", 32'(cnt), 32'(hold + 1));
            check("awready_after_b", 32'(awready), 32'd1);
        end
        bready = 1'b0;
        $display("burst addr=%04h beats=%0d hold=%0d exp_resp=%0d", addr, n, hold, err ? 2 : 0);
    endtask

    task automatic play(input int div, input int len, input int cycles);
        int le;
        int t;
        le = (len == 0) ? 1 : ((len > DEPTH) ? DEPTH : len);
        @(posedge clk); #1;
        cfg_div = 16'(div);
        cfg_len = (ADDR_W + 1)'(len);
        play_en = 1'b1;
        dac_q.push_back(128);
        for (int m = 1; m <= cycles; m++) begin
            @(posedge clk); #1;
            dac_q.push_back(exp_sample(m, div, le));
        end
        play_en = 1'b0;
        @(posedge clk); #1;
        dac_q.push_back(128);
        t = 0;
        while (dac_q.size() > 0 && t < 10) begin
            @(posedge clk);
            t++;
        end
        check("dac_queue_drained", 32'(dac_q.size()), 32'd0);
        $display("play div=%0d len=%0d cycles=%0d", div, len, cycles);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b0; play_en = 1'b0; cfg_div = '0; cfg_len = '0;
        repeat (3) @(posedge clk);
        #1 axi_areset = 1'b0;
        @(negedge clk);
        check("reset_awready_low", 32'(awready), 32'd0);
        check("reset_wready", 32'(wready), 32'd0);
        check("reset_bresp", 32'(bresp), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("idle_awready", 32'(awready), 32'd1);
        check("idle_bvalid", 32'(bvalid), 32'd0);
        check("idle_dac", 32'(dac_data), 32'h80);
        $display("reset checked");

        for (int i = 0; i < DEPTH; i++) bd[i] = 8'($urandom);
        burst(16'h0000, DEPTH, 0, -1);

        bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33; bd[3] = 8'h44;
        burst(16'h0000, 4, 0, -1);
        play(0, 4, 12);

        bd[0] = 8'hAA; bd[1] = 8'hBB; bd[2] = 8'hCC; bd[3] = 8'hDD;
        burst(16'h03FE, 4, 0, -1);
        play(0, 2047, DEPTH + 6);

        bd[0] = 8'h01; bd[1] = 8'h02;
        burst(16'h0000, 2, 0, -1);
        play(3, 2, 14);
        play(2, 0, 10);

        bd[0] = 8'h9C; bd[1] = 8'h3D;
        burst(16'h0020, 2, 5, -1);
        bd[0] = 8'h77;
        burst(16'h0022, 1, 0, -1);

        bd[0] = 8'hE1; bd[1] = 8'hE2; bd[2] = 8'hE3;
        burst(16'hFFFF, 3, 0, -1);
        play(1, 3, 10);

        bd[0] = 8'h61; bd[1] = 8'h62; bd[2] = 8'h63; bd[3] = 8'h64;
        burst(16'h0200, 4, 0, 1);
        bd[0] = 8'h5A;
        burst(16'h0010, 1, 0, -1);
        play(0, 17, 20);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) bd[i] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) burst(16'($urandom_range(1018, 1023)), n, $urandom_range(0, 3), -1);
            else burst(16'($urandom_range(0, 60)), n, $urandom_range(0, 3), -1);
            play($urandom_range(0, 4), $urandom_range(0, 64), 30);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
